serial_operand_serializer: RTL and testbench

//   Upstream stage of the serial adder: accepts a pair of WIDTH-bit operands

---
 rtl/serial_pkg.sv | 5 +
 rtl/serial_bit_counter.sv | 37 +++
 rtl/serial_operand_serializer.sv | 85 ++++++++
 tb/tb_serial_operand_serializer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial operand path (serializer and adder).
package serial_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;
    localparam int SERIAL_WIDTH_DEFAULT = 16;
endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for one serialized word: cleared on load, advances while en.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     is_first,
    output logic                     is_last
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Wrap at the last bit so the count returns to 0 when the FSM drops to IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = '0;
        else if (en)
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt      = cnt_q;
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == LAST_IDX);
endmodule

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand feeder for the serial adder, LSB first with word framing.
// Define SERIALIZER_BUBBLE_EN to force one idle cycle between consecutive words.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CW-1:0]    cnt;
    logic             cnt_first, cnt_last;
    logic             in_shift, xfer;

    assign in_shift = (state_q == SHIFT);

`ifdef SERIALIZER_BUBBLE_EN
    assign up_ready = ~rst & (state_q == IDLE);
`else
    assign up_ready = ~rst & ((state_q == IDLE) | (in_shift & cnt_last));
`endif

    assign xfer = up_valid & up_ready;

    serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (xfer),
        .en       (in_shift),
        .cnt      (cnt),
        .is_first (cnt_first),
        .is_last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        unique case (state_q)
            IDLE: if (xfer) state_d = SHIFT;
            SHIFT: if (cnt_last && !xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A reload takes priority over the final shift of the outgoing word.
        if (xfer) begin
            sh_a_d = up_a;
            sh_b_d = up_b;
        end else if (in_shift) begin
            sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
        end
    end

    assign a         = in_shift & sh_a_q[0];
    assign b         = in_shift & sh_b_q[0];
    assign bit_valid = in_shift;
    assign first     = in_shift & cnt_first;
    assign last      = in_shift & cnt_last;
endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer at WIDTH=16.
module tb_serial_operand_serializer;
    import serial_pkg::*;
    localparam int W = 16;

    logic         clk, rst, up_valid, up_ready;
    logic [W-1:0] up_a, up_b;
    logic         a, b, bit_valid, first, last;
    int           total = 0;
    int           bad   = 0;

`ifdef SERIALIZER_BUBBLE_EN
    localparam logic RDY_AT_LAST = 1'b0;
`else
    localparam logic RDY_AT_LAST = 1'b1;
`endif

    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready),
        .up_a(up_a), .up_b(up_b), .a(a), .b(b), .bit_valid(bit_valid),
        .first(first), .last(last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector layout: {up_ready, last, first, bit_valid, b, a}
    function automatic logic [5:0] obs();
        return {up_ready, last, first, bit_valid, b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at cycle 1 of a word; returns at its last bit. Optionally pulses
    // up_valid with junk at bit index pulse_at to confirm it is ignored.
    task automatic expect_word(input string tag, input logic [W-1:0] ea,
                               input logic [W-1:0] eb, input int pulse_at);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("%s.bit%0d", tag, k), 32'(obs()),
                32'({(k == W-1) ? RDY_AT_LAST : 1'b0, k == W-1, k == 0, 1'b1, eb[k], ea[k]}));
            if (k == pulse_at) begin
                up_valid = 1'b1; up_a = 16'h5A5A; up_b = 16'hFFFF;
            end else if (k == pulse_at + 1) begin
                up_valid = 1'b0;
            end
            if (k < W-1) step();
        end
    endtask

    initial begin
        logic [W-1:0] sum;
        logic         c;
        int           idx;
        rst = 1'b1; up_valid = 1'b0; up_a = '0; up_b = '0;
        #1;
        chk("reset0.outs", 32'(obs()), 32'h00);
        step(); step();
        rst = 1'b0;
        #1;
        chk("idle.after_reset", 32'(obs()), 32'h20);

        // Reset mid-stream
        up_valid = 1'b1; up_a = 16'hFFFF; up_b = 16'hFFFF;
        step(); up_valid = 1'b0;
        step(); step(); step();
        chk("midword.live", 32'(obs()), 32'h07);
        rst = 1'b1; #1;
        chk("rst.async", 32'(obs()), 32'h00);
        step();
        chk("rst.hold1", 32'(obs()), 32'h00);
        step();
        chk("rst.hold2", 32'(obs()), 32'h00);
        rst = 1'b0; #1;
        chk("rst.release", 32'(obs()), 32'h20);
        step();
        chk("rst.no_restart", 32'(obs()), 32'h20);

        // Single word
        up_valid = 1'b1; up_a = 16'h0003; up_b = 16'h0001;
        step(); up_valid = 1'b0;
        expect_word("single", 16'h0003, 16'h0001, -10);
        step();
        chk("single.after", 32'(obs()), 32'h20);
        step();
        chk("single.idle2", 32'(obs()), 32'h20);

        // Back-to-back with up_valid held
        up_valid = 1'b1; up_a = 16'hFFFF; up_b = 16'h0001;
        step(); up_a = 16'h00F0; up_b = 16'h0F00;
        expect_word("b2b.w0", 16'hFFFF, 16'h0001, -10);
        step();
`ifdef SERIALIZER_BUBBLE_EN
        chk("bubble.gap", 32'(obs()), 32'h20);
        step();
`endif
        up_valid = 1'b0;
        expect_word("b2b.w1", 16'h00F0, 16'h0F00, -10);
        step();
        chk("b2b.after", 32'(obs()), 32'h20);

        // Stall: pulse during the word must be ignored
        up_valid = 1'b1; up_a = 16'hA5C3; up_b = 16'h3C5A;
        step(); up_valid = 1'b0;
        expect_word("stall", 16'hA5C3, 16'h3C5A, 4);
        step();
        chk("stall.after", 32'(obs()), 32'h20);

        // Chained with a serial adder model, carry cleared on first
        up_valid = 1'b1; up_a = 16'h4981; up_b = 16'h2A84;
        step(); up_valid = 1'b0;
        sum = '0; c = 1'b0; idx = 0;
        for (int k = 0; k < 40 && idx < W; k++) begin
            if (bit_valid) begin
                if (first) begin c = 1'b0; idx = 0; end
                sum[idx] = a ^ b ^ c;
                c = (a & b) | (a & c) | (b & c);
                idx++;
            end
            if (idx < W) step();
        end
        chk("adder.bits", 32'(idx), 32'(W));
        chk("adder.sum", 32'(sum), 32'h7405);
        step();
        chk("adder.after", 32'(obs()), 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
